// File: rtl/i2c_slave_responder.sv
// I2C target: acks SLAVE_ADDR, streams write bytes out on wr_valid, fetches read bytes via rd_req/rd_valid.
// Latency: bus events act SYNC_STAGES+1 clk after they reach scl_i/sda_i; wr_valid fires on the 8th SCL rise.
// Backpressure: write path never stalls (always ACK); read path stretches SCL until rd_valid when STRETCH_EN=1.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         SYNC_STAGES = 2,
    parameter bit         STRETCH_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       s_rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_WAIT, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_cond, stop_cond;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rd_buf;
    logic       rw;
    logic       stretching;
    logic       rd_pend;
    logic       rd_have;
    logic       rd_take;
    logic [7:0] byte_in;
    logic [7:0] rd_load;

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;
    assign rd_take    = rd_pend & rd_valid;
    assign byte_in    = {shreg[6:0], sda_s};
    assign rd_load    = rd_have ? rd_buf : rd_data;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            rd_buf     <= 8'd0;
            rw         <= 1'b0;
            stretching <= 1'b0;
            rd_pend    <= 1'b0;
            rd_have    <= 1'b0;
            scl_o      <= 1'b1;
            sda_o      <= 1'b1;
            wr_data    <= 8'd0;
            wr_valid   <= 1'b0;
            rd_req     <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            rd_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;

            // Latch the first rd_valid after a request; later branches may override (START discards it).
            if (rd_take) begin
                rd_buf  <= rd_data;
                rd_have <= 1'b1;
                rd_pend <= 1'b0;
            end

            if (start_cond) begin
                start_det  <= 1'b1;
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                scl_o      <= 1'b1;
                sda_o      <= 1'b1;
                stretching <= 1'b0;
                rd_pend    <= 1'b0;
                rd_have    <= 1'b0;
            end else if (stop_cond) begin
                stop_det   <= 1'b1;
                state      <= IDLE;
                busy       <= 1'b0;
                scl_o      <= 1'b1;
                sda_o      <= 1'b1;
                stretching <= 1'b0;
                rd_pend    <= 1'b0;
                rd_have    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state <= ADDR_ACK;
                                busy  <= 1'b1;
                                rw    <= byte_in[0];
                            end else begin
                                state <= IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        sda_o <= 1'b0;
                    end else if (scl_rise) begin
                        if (rw) begin
                            rd_req  <= 1'b1;
                            rd_pend <= 1'b1;
                            rd_have <= 1'b0;
                            state   <= RD_WAIT;
                        end else begin
                            bit_cnt <= 3'd0;
                            state   <= WR_BYTE;
                        end
                    end
                    WR_BYTE: if (scl_fall) begin
                        sda_o <= 1'b1;
                    end else if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            wr_data  <= byte_in;
                            wr_valid <= 1'b1;
                            state    <= WR_ACK;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        sda_o <= 1'b0;
                    end else if (scl_rise) begin
                        state <= WR_BYTE;
                    end
                    // The ACK from the previous bit is still on SDA until this fall.
                    RD_WAIT: if (scl_fall || stretching) begin
                        if (rd_have || rd_take) begin
                            shreg      <= rd_load;
                            sda_o      <= rd_load[7];
                            scl_o      <= 1'b1;
                            stretching <= 1'b0;
                            rd_have    <= 1'b0;
                            bit_cnt    <= 3'd0;
                            state      <= RD_BYTE;
                        end else if (STRETCH_EN) begin
                            scl_o      <= 1'b0;
                            sda_o      <= 1'b1;
                            stretching <= 1'b1;
                        end else begin
                            shreg   <= 8'hFF;
                            sda_o   <= 1'b1;
                            rd_pend <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= RD_BYTE;
                        end
                    end
                    RD_BYTE: if (scl_fall) begin
                        sda_o <= shreg[7];
                    end else if (scl_rise) begin
                        shreg   <= {shreg[6:0], 1'b1};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= RD_ACK;
                    end
                    RD_ACK: if (scl_fall) begin
                        sda_o <= 1'b1;
                    end else if (scl_rise) begin
                        if (!sda_s) begin
                            rd_req  <= 1'b1;
                            rd_pend <= 1'b1;
                            rd_have <= 1'b0;
                            state   <= RD_WAIT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IGNORE;
                        end
                    end
                    IGNORE: begin
                        scl_o <= 1'b1;
                        sda_o <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master on a wired-AND bus with a stretching target (0x22) and a non-stretching one (0x23).
// Read bytes are served by a delayed rd_req/rd_valid responder; all checks are immediate assertions.
module tb_i2c_slave_responder;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst;
    logic m_scl, m_sda;

    logic       scl_o0, sda_o0, wr_valid0, rd_req0, start_det0, stop_det0, busy0;
    logic [7:0] wr_data0;
    logic [7:0] rd_data0;
    logic       rd_valid0;

    logic       scl_o1, sda_o1, wr_valid1, rd_req1, start_det1, stop_det1, busy1;
    logic [7:0] wr_data1;
    logic [7:0] rd_data1;
    logic       rd_valid1;

    wire scl_bus = m_scl & scl_o0 & scl_o1;
    wire sda_bus = m_sda & sda_o0 & sda_o1;

    always #5 clk = ~clk;

    i2c_slave_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .s_rst(rst), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_o(scl_o0), .sda_o(sda_o0), .wr_data(wr_data0), .wr_valid(wr_valid0),
        .rd_req(rd_req0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .start_det(start_det0), .stop_det(stop_det0), .busy(busy0));

    i2c_slave_responder #(.SLAVE_ADDR(7'h23), .SYNC_STAGES(2), .STRETCH_EN(1'b0)) dut_ns (
        .clk(clk), .s_rst(rst), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_o(scl_o1), .sda_o(sda_o1), .wr_data(wr_data1), .wr_valid(wr_valid1),
        .rd_req(rd_req1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .start_det(start_det1), .stop_det(stop_det1), .busy(busy1));

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0, rd_cnt = 0, st_cnt = 0, sp_cnt = 0;
    logic [7:0] wr_log [0:63];
    logic       ns_stretched = 1'b0;
    int         rd_delay;
    logic [7:0] rd_q [0:3];
    int         rd_idx = 0;
    int         cd = 0;
    int         max_stretch;

    // Pulse monitor for the stretching target, plus a sticky flag for the non-stretching one.
    always @(negedge clk) begin
        if (wr_valid0 === 1'b1) begin
            wr_log[wr_cnt] = wr_data0;
            wr_cnt++;
        end
        if (rd_req0 === 1'b1) rd_cnt++;
        if (start_det0 === 1'b1) st_cnt++;
        if (stop_det0 === 1'b1) sp_cnt++;
        if (scl_o1 === 1'b0) ns_stretched = 1'b1;
    end

    // Read-data source: answers each rd_req with one rd_valid pulse rd_delay cycles later.
    always @(negedge clk) begin
        rd_valid0 = 1'b0;
        if (rd_req0 === 1'b1) begin
            cd = rd_delay;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                rd_valid0 = 1'b1;
                rd_data0  = rd_q[rd_idx];
                rd_idx++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_hi();
        int w = 0;
        m_scl = 1'b1;
        #1;
        while (scl_bus !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) chk("scl_release", 32'(scl_bus), 32'd1);
        if (w > max_stretch) max_stretch = w;
    endtask

    task automatic send_bit(input logic b);
        m_scl = 1'b0; clks(Q);
        m_sda = b;    clks(Q);
        scl_hi();     clks(2*Q);
    endtask

    task automatic recv_bit(output logic b);
        m_scl = 1'b0; clks(Q);
        m_sda = 1'b1; clks(Q);
        scl_hi();     clks(Q);
        b = sda_bus;  clks(Q);
    endtask

    task automatic bus_start();
        m_scl = 1'b0; clks(Q);
        m_sda = 1'b1; clks(Q);
        scl_hi();     clks(Q);
        m_sda = 1'b0; clks(2*Q);
    endtask

    task automatic bus_stop();
        m_scl = 1'b0; clks(Q);
        m_sda = 1'b0; clks(Q);
        scl_hi();     clks(Q);
        m_sda = 1'b1; clks(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bt);
            d[i] = bt;
        end
        send_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d1, d2;
        int         wb, rb, sb, pb;

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        rd_delay = 5;
        rd_q[0] = 8'h96; rd_q[1] = 8'h01; rd_q[2] = 8'h02; rd_q[3] = 8'h00;
        rd_data1 = 8'h00; rd_valid1 = 1'b0;
        clks(5);
        rst = 1'b0;
        clks(4);

        // Reset values
        chk("rst_scl_o", 32'(scl_o0), 32'd1);
        chk("rst_sda_o", 32'(sda_o0), 32'd1);
        chk("rst_wr_data", 32'(wr_data0), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid0), 32'd0);
        chk("rst_rd_req", 32'(rd_req0), 32'd0);
        chk("rst_start_det", 32'(start_det0), 32'd0);
        chk("rst_stop_det", 32'(stop_det0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);

        // Write 0x44, A5, 3C, STOP
        wb = wr_cnt; pb = sp_cnt;
        bus_start();
        send_byte(8'h44, ack); chk("w1_addr_ack", 32'(ack), 32'd0);
        chk("w1_busy", 32'(busy0), 32'd1);
        send_byte(8'hA5, ack); chk("w1_d0_ack", 32'(ack), 32'd0);
        send_byte(8'h3C, ack); chk("w1_d1_ack", 32'(ack), 32'd0);
        bus_stop();
        chk("w1_wr_count", 32'(wr_cnt - wb), 32'd2);
        chk("w1_wr0", 32'(wr_log[wb]), 32'hA5);
        chk("w1_wr1", 32'(wr_log[wb+1]), 32'h3C);
        chk("w1_stop_det", 32'(sp_cnt - pb), 32'd1);
        chk("w1_busy_end", 32'(busy0), 32'd0);

        // Foreign address 0x50 (byte 0xA0)
        wb = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack); chk("nomatch_ack", 32'(ack), 32'd1);
        chk("nomatch_busy", 32'(busy0), 32'd0);
        send_byte(8'h77, ack);
        bus_stop();
        chk("nomatch_wr_count", 32'(wr_cnt - wb), 32'd0);

        // Read with rd_valid 200 clk after rd_req: SCL stretched
        rd_delay = 200; max_stretch = 0;
        bus_start();
        send_byte(8'h45, ack); chk("r1_addr_ack", 32'(ack), 32'd0);
        recv_byte(1'b1, d1);
        chk("r1_data", 32'(d1), 32'h96);
        chk("r1_stretch_window", 32'(max_stretch > 150 && max_stretch < 200), 32'd1);
        chk("r1_busy_after_nack", 32'(busy0), 32'd0);
        bus_stop();

        // Write 0x11, repeated START, read two bytes
        rd_delay = 5; max_stretch = 0;
        wb = wr_cnt; rb = rd_cnt; sb = st_cnt;
        bus_start();
        send_byte(8'h44, ack); chk("rs_waddr_ack", 32'(ack), 32'd0);
        send_byte(8'h11, ack);
        bus_start();
        send_byte(8'h45, ack); chk("rs_raddr_ack", 32'(ack), 32'd0);
        recv_byte(1'b0, d1);
        recv_byte(1'b1, d2);
        bus_stop();
        chk("rs_start_det", 32'(st_cnt - sb), 32'd2);
        chk("rs_wr_count", 32'(wr_cnt - wb), 32'd1);
        chk("rs_wr0", 32'(wr_log[wb]), 32'h11);
        chk("rs_rd_req", 32'(rd_cnt - rb), 32'd2);
        chk("rs_rd0", 32'(d1), 32'h01);
        chk("rs_rd1", 32'(d2), 32'h02);
        chk("rs_no_stretch", 32'(max_stretch), 32'd0);

        // Reset while target drives a 0 bit in RD_BYTE
        bus_start();
        send_byte(8'h45, ack);
        m_scl = 1'b0; clks(Q);
        chk("rst_mid_pre_sda", 32'(sda_o0), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_sda_o", 32'(sda_o0), 32'd1);
        chk("rst_mid_scl_o", 32'(scl_o0), 32'd1);
        chk("rst_mid_busy", 32'(busy0), 32'd0);
        m_scl = 1'b1; m_sda = 1'b1;
        clks(4);
        rst = 1'b0;
        clks(4);
        wb = wr_cnt;
        bus_start();
        send_byte(8'h44, ack); chk("post_rst_ack", 32'(ack), 32'd0);
        send_byte(8'h5A, ack);
        bus_stop();
        chk("post_rst_wr", 32'(wr_log[wb]), 32'h5A);

        // Non-stretching target at 0x23 with no rd_valid: reads 0xFF
        max_stretch = 0;
        bus_start();
        send_byte(8'h47, ack); chk("ns_addr_ack", 32'(ack), 32'd0);
        recv_byte(1'b1, d1);
        bus_stop();
        chk("ns_data", 32'(d1), 32'hFF);
        chk("ns_scl_held", 32'(ns_stretched), 32'd0);
        chk("ns_max_stretch", 32'(max_stretch), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
